// File: rtl/daisy_chain_irq_ctrl_if.sv
// Request/acknowledge bundle between peripherals, the CPU and the daisy-chain controller.
interface daisy_chain_irq_ctrl_if #(
  parameter int N_DEV = 4,
  parameter int VEC_W = 8
);
  logic [N_DEV-1:0] irq_req_n;
  logic             irq_chain_in_n;
  logic             ack_in_n;
  logic             eoi;
  logic             irq_out_n;
  logic             ack_out_n;
  logic [N_DEV-1:0] ack_k_n;
  logic [VEC_W-1:0] vec;
  logic             vec_valid;
  logic             busy;

  modport master (
    output irq_req_n, irq_chain_in_n, ack_in_n, eoi,
    input  irq_out_n, ack_out_n, ack_k_n, vec, vec_valid, busy
  );

  modport slave (
    input  irq_req_n, irq_chain_in_n, ack_in_n, eoi,
    output irq_out_n, ack_out_n, ack_k_n, vec, vec_valid, busy
  );
endinterface

// File: rtl/daisy_chain_irq_ctrl.sv
// Clocked daisy-chain interrupt priority controller with cascade forwarding.
// Optional rotating priority: define DAISY_ROTATE_PRIO_EN.
module daisy_chain_irq_ctrl #(
  parameter int               N_DEV    = 4,
  parameter int               VEC_W    = 8,
  parameter logic [VEC_W-1:0] BASE_VEC = VEC_W'(8'h20)
) (
  input logic              clk,
  input logic              rst,
  daisy_chain_irq_ctrl_if.slave bus
);

  localparam int W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  // state   | meaning
  // IDLE    | waiting for an acknowledge
  // GRANT   | local winner driven on ack_k_n / vec
  // PASS    | acknowledge forwarded downstream
  // SERVICE | local device in service until eoi
  typedef enum logic [1:0] {IDLE, GRANT, PASS, SERVICE} state_t;

  state_t           state, state_nx;
  logic [N_DEV-1:0] pending, req_q, fall, clr;
  logic [W-1:0]     win_q, win_sel;
  logic             grant_go;
  logic             irq_q;
  logic [N_DEV-1:0] ack_k_n;
  logic             ack_out_n;
  logic [VEC_W-1:0] vec;
  logic             vec_valid;
  logic             busy;

  assign fall = req_q & ~bus.irq_req_n;
  assign clr  = grant_go ? (N_DEV'(1) << win_sel) : '0;

`ifdef DAISY_ROTATE_PRIO_EN
  logic [W-1:0] last_srv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_srv <= '0;
    else if (grant_go) last_srv <= win_sel;
  end

  // Scan downward so the first pending index after last_srv ends up selected.
  always_comb begin
    win_sel = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (pending[(int'(last_srv) + 1 + i) % N_DEV])
        win_sel = W'((int'(last_srv) + 1 + i) % N_DEV);
    end
  end
`else
  always_comb begin
    win_sel = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (pending[i]) win_sel = W'(i);
    end
  end
`endif

  always_comb begin
    state_nx  = state;
    grant_go  = 1'b0;
    ack_k_n   = '1;
    ack_out_n = 1'b1;
    vec       = '0;
    vec_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.ack_in_n) begin
          if (|pending) begin
            grant_go = 1'b1;
            state_nx = GRANT;
          end else begin
            state_nx = PASS;
          end
        end
      end
      GRANT: begin
        ack_k_n   = ~(N_DEV'(1) << win_q);
        vec       = BASE_VEC + VEC_W'(win_q);
        vec_valid = 1'b1;
        if (bus.ack_in_n) state_nx = SERVICE;
      end
      PASS: begin
        ack_out_n = bus.ack_in_n;
        if (bus.ack_in_n) state_nx = IDLE;
      end
      SERVICE: begin
        busy      = 1'b1;
        ack_out_n = bus.ack_in_n;
        if (bus.eoi) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // req_q resets low so a request held through reset is not seen as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      req_q   <= '0;
      win_q   <= '0;
      irq_q   <= 1'b1;
    end else begin
      state   <= state_nx;
      req_q   <= bus.irq_req_n;
      pending <= (pending & ~clr) | fall;
      irq_q   <= ~(((|pending) && (state == IDLE)) || !bus.irq_chain_in_n);
      if (grant_go) win_q <= win_sel;
    end
  end

  assign bus.irq_out_n = irq_q;
  assign bus.ack_out_n = ack_out_n;
  assign bus.ack_k_n   = ack_k_n;
  assign bus.vec       = vec;
  assign bus.vec_valid = vec_valid;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_daisy_chain_irq_ctrl.sv
// Scoreboard bench for daisy_chain_irq_ctrl: grants and forwarded acks checked by a monitor.
module tb_daisy_chain_irq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  daisy_chain_irq_ctrl_if #(.N_DEV(4), .VEC_W(8)) bus ();

  daisy_chain_irq_ctrl #(.N_DEV(4), .VEC_W(8), .BASE_VEC(8'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       pass;
    logic [3:0] ack_k;
    logic [7:0] vec;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t grant_rec(input logic [3:0] k, input logic [7:0] v);
    exp_t e;
    e.pass = 1'b0; e.ack_k = k; e.vec = v;
    return e;
  endfunction

  function automatic exp_t pass_rec();
    exp_t e;
    e.pass = 1'b1; e.ack_k = 4'hf; e.vec = 8'h00;
    return e;
  endfunction

  // Monitor: a rising vec_valid is a grant, a falling ack_out_n is a forwarded ack.
  initial begin
    logic prev_vv;
    logic prev_ao;
    exp_t e;
    prev_vv = 1'b0;
    prev_ao = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.vec_valid && !prev_vv) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got ack_k_n=%b want no grant", bus.ack_k_n);
        end else begin
          e = q.pop_front();
          check("grant_kind", 32'(1'b0), 32'(e.pass));
          check("grant_ack_k_n", 32'(bus.ack_k_n), 32'(e.ack_k));
          check("grant_vec", 32'(bus.vec), 32'(e.vec));
          check("grant_no_fwd", 32'(bus.ack_out_n), 32'(1'b1));
        end
      end
      if (!bus.ack_out_n && prev_ao) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pass: got ack_out_n=0 want 1");
        end else begin
          e = q.pop_front();
          check("pass_kind", 32'(1'b1), 32'(e.pass));
          check("pass_ack_k_n", 32'(bus.ack_k_n), 32'(4'hf));
          check("pass_vec_valid", 32'(bus.vec_valid), 32'(1'b0));
        end
      end
      prev_vv = bus.vec_valid;
      prev_ao = bus.ack_out_n;
    end
  end

  task automatic ack_round(input int low_cycles);
    bus.ack_in_n = 1'b0;
    repeat (low_cycles) tick();
    bus.ack_in_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.irq_req_n      = 4'b1111;
    bus.irq_chain_in_n = 1'b1;
    bus.ack_in_n       = 1'b1;
    bus.eoi            = 1'b0;

    repeat (3) tick();
    check("rst_irq_out_n", 32'(bus.irq_out_n), 32'(1'b1));
    check("rst_ack_k_n", 32'(bus.ack_k_n), 32'(4'hf));
    check("rst_vec", 32'(bus.vec), 32'(8'h00));
    rst = 1'b0;
    repeat (2) tick();
    check("idle_irq_out_n", 32'(bus.irq_out_n), 32'(1'b1));
    check("idle_vec_valid", 32'(bus.vec_valid), 32'(1'b0));
    check("idle_busy", 32'(bus.busy), 32'(1'b0));
    check("idle_ack_out_n", 32'(bus.ack_out_n), 32'(1'b1));

    // single request on device 2
    bus.irq_req_n = 4'b1011;
    tick();
    check("irq_latency_0", 32'(bus.irq_out_n), 32'(1'b1));
    tick();
    check("irq_latency_1", 32'(bus.irq_out_n), 32'(1'b0));
    q.push_back(grant_rec(4'b1011, 8'h22));
    ack_round(3);
    check("svc_busy", 32'(bus.busy), 32'(1'b1));
    check("svc_ack_k_n", 32'(bus.ack_k_n), 32'(4'hf));
    check("svc_vec_valid", 32'(bus.vec_valid), 32'(1'b0));
    bus.irq_req_n = 4'b1111;

    // nested acknowledge while in service is forwarded
    q.push_back(pass_rec());
    bus.ack_in_n = 1'b0;
    tick();
    check("nested_ack_out_n", 32'(bus.ack_out_n), 32'(1'b0));
    check("nested_busy", 32'(bus.busy), 32'(1'b1));
    bus.ack_in_n = 1'b1;
    tick();

    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    check("eoi_busy", 32'(bus.busy), 32'(1'b0));
    tick();
    check("eoi_irq_out_n", 32'(bus.irq_out_n), 32'(1'b1));

    // devices 1 and 3 together
    bus.irq_req_n = 4'b0101;
    tick();
    tick();
    check("dual_irq_out_n", 32'(bus.irq_out_n), 32'(1'b0));
`ifdef DAISY_ROTATE_PRIO_EN
    q.push_back(grant_rec(4'b0111, 8'h23));
`else
    q.push_back(grant_rec(4'b1101, 8'h21));
`endif
    ack_round(2);
    check("dual_svc_busy", 32'(bus.busy), 32'(1'b1));
    check("dual_svc_irq_masked", 32'(bus.irq_out_n), 32'(1'b1));
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    check("dual_second_irq", 32'(bus.irq_out_n), 32'(1'b0));
`ifdef DAISY_ROTATE_PRIO_EN
    q.push_back(grant_rec(4'b1101, 8'h21));
`else
    q.push_back(grant_rec(4'b0111, 8'h23));
`endif
    ack_round(2);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    check("dual_done_irq", 32'(bus.irq_out_n), 32'(1'b1));
    bus.irq_req_n = 4'b1111;

    // cascaded request only
    bus.irq_chain_in_n = 1'b0;
    tick();
    check("chain_irq_out_n", 32'(bus.irq_out_n), 32'(1'b0));
    q.push_back(pass_rec());
    bus.ack_in_n = 1'b0;
    tick();
    check("chain_ack_out_n", 32'(bus.ack_out_n), 32'(1'b0));
    check("chain_ack_k_n", 32'(bus.ack_k_n), 32'(4'hf));
    check("chain_vec_valid", 32'(bus.vec_valid), 32'(1'b0));
    tick();
    bus.ack_in_n = 1'b1;
    #1;
    check("chain_ack_release", 32'(bus.ack_out_n), 32'(1'b1));
    tick();
    bus.irq_chain_in_n = 1'b1;
    tick();
    check("chain_irq_release", 32'(bus.irq_out_n), 32'(1'b1));

    // request arriving during PASS is held for the next acknowledge
    q.push_back(pass_rec());
    bus.ack_in_n = 1'b0;
    tick();
    bus.irq_req_n = 4'b1110;
    tick();
    tick();
    check("pass_hold_no_grant", 32'(bus.ack_k_n), 32'(4'hf));
    bus.ack_in_n = 1'b1;
    tick();
    tick();
    check("pass_hold_irq", 32'(bus.irq_out_n), 32'(1'b0));

    // grant device 0, then reset mid-grant
    q.push_back(grant_rec(4'b1110, 8'h20));
    bus.ack_in_n = 1'b0;
    tick();
    check("dev0_ack_k_n", 32'(bus.ack_k_n), 32'(4'b1110));
    tick();
    rst = 1'b1;
    #1;
    check("abort_ack_k_n", 32'(bus.ack_k_n), 32'(4'hf));
    check("abort_vec_valid", 32'(bus.vec_valid), 32'(1'b0));
    check("abort_irq_out_n", 32'(bus.irq_out_n), 32'(1'b1));
    bus.ack_in_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("no_regrant_irq", 32'(bus.irq_out_n), 32'(1'b1));
    q.push_back(pass_rec());
    ack_round(2);
    bus.irq_req_n = 4'b1111;
    tick();
    bus.irq_req_n = 4'b1110;
    tick();
    tick();
    check("new_edge_irq", 32'(bus.irq_out_n), 32'(1'b0));

    repeat (2) tick();
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/daisy_chain_irq_ctrl.md
Name: daisy_chain_irq_ctrl

Overview:
- Parametrised, clocked successor to the single-stage active-low daisy-chain priority cell.
- Arbitrates N_DEV local active-low interrupt requests and merges a cascaded request from a downstream block into one active-low IRQ to the CPU.
- On CPU acknowledge, grants the highest-priority pending device with an active-low per-device ACK and a vector, or forwards the ACK down the chain when nothing local is pending.
- Sits between peripherals and the CPU interrupt pin; instances cascade through irq_chain_in_n / ack_out_n.

Parameters:
- N_DEV, 4: number of local requesters, 1..16.
- VEC_W, 8: vector width.
- BASE_VEC, 8'h20: vector for device 0; device k gets BASE_VEC+k, truncated to VEC_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- irq_req_n  in  N_DEV  device requests, active low; bit 0 has the highest fixed priority.
- irq_chain_in_n  in  1  request from the downstream block, active low.
- ack_in_n  in  1  acknowledge from the CPU or upstream block, active low, level.
- eoi  in  1  end-of-interrupt strobe, active high, one cycle.
- irq_out_n  out  1  merged request, active low.
- ack_out_n  out  1  acknowledge forwarded downstream, active low.
- ack_k_n  out  N_DEV  per-device grant, active low, one-hot-low.
- vec  out  VEC_W  vector of the granted device.
- vec_valid  out  1  vec is valid, active high.
- busy  out  1  a local device is in service.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; pending=0.
  - irq_out_n=1, ack_out_n=1, ack_k_n=all 1s, vec=0, vec_valid=0, busy=0.
  - A reset asserted mid-operation aborts any grant immediately; pending requests are dropped.
- Request capture:
  - pending[k] sets on a registered falling edge of irq_req_n[k]: previous sample 1, current sample 0.
  - pending[k] clears only when device k is granted.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- irq_out_n is registered: low when (|pending and state==IDLE) or irq_chain_in_n==0. One cycle of latency from pending to irq_out_n.
- FSM states: IDLE, GRANT, PASS, SERVICE.
- IDLE:
  - If ack_in_n==0 and |pending: choose winner w = the lowest-index pending bit; clear pending[w]; go to GRANT.
  - If ack_in_n==0 and pending==0: go to PASS.
- GRANT:
  - ack_k_n[w]=0, vec=BASE_VEC+w, vec_valid=1, valid on the first GRANT cycle.
  - Winner selection and outputs are registered: one cycle from ack_in_n low to ack_k_n low.
  - When ack_in_n returns to 1: ack_k_n returns to all 1s, vec_valid=0, go to SERVICE.
- PASS:
  - ack_out_n=0 while ack_in_n==0.
  - When ack_in_n returns to 1: ack_out_n=1, go to IDLE.
  - New pending bits captured during PASS are held and are not granted in this acknowledge.
- SERVICE:
  - busy=1; local requests stay pending but irq_out_n reflects only irq_chain_in_n.
  - eoi==1: busy=0, go to IDLE.
  - ack_in_n==0 while in SERVICE (nested acknowledge) goes to PASS-like forwarding: ack_out_n follows ack_in_n and the state stays SERVICE.
- eoi outside SERVICE is ignored.
- Winner index width is clog2(N_DEV), minimum 1. vec addition wraps modulo 2^VEC_W.
- Only one ack_k_n bit is ever low. ack_out_n and any ack_k_n bit are never low in the same cycle.

Optional Feature:
- Macro DAISY_ROTATE_PRIO_EN.
- Defined:
  - Rotating priority. A last_srv register (reset 0) records the last winner.
  - The search starts at last_srv+1 and wraps modulo N_DEV, so the last-served device becomes lowest priority.
  - last_srv updates on entry to GRANT.
- Undefined: fixed priority, with bit 0 highest.

Test Plan:
- Reset, then irq_req_n=4'b1111 and no ack -> irq_out_n=1, ack_k_n=4'b1111, vec_valid=0.
- Bring irq_req_n[2] low; pulse ack_in_n low for 3 cycles -> irq_out_n low one cycle after the edge; ack_k_n=4'b1011 and vec=8'h22 with vec_valid=1 during ack; busy=1 after ack releases; eoi -> busy=0, irq_out_n=1.
- Bring irq_req_n[1] and [3] low in the same cycle; run two ack/eoi rounds -> first grant 4'b1101 / vec 8'h21, second 4'b0111 / vec 8'h23.
  - With DAISY_ROTATE_PRIO_EN and last_srv=1 (prior grant of device 1), same stimulus -> device 3 is granted first.
- No local pending, irq_chain_in_n=0 -> irq_out_n=0; ack_in_n low -> ack_out_n=0, ack_k_n=4'b1111, vec_valid=0.
- Assert rst during GRANT of device 0 -> ack_k_n=4'b1111, vec_valid=0, irq_out_n=1 without waiting for a clock edge; after release, no grant occurs until a new falling edge on irq_req_n.
